// File: rtl/lvds_video_in_if.sv
// rtl/lvds_video_in_if.sv - lane-word inputs and decoded video outputs of the LVDS video receiver
interface lvds_video_in_if;
  logic [6:0]  in_1a_data;
  logic [6:0]  in_1b_data;
  logic [6:0]  in_1c_data;
  logic [6:0]  in_1d_data;
  logic [6:0]  in_2a_data;
  logic [6:0]  in_2b_data;
  logic [6:0]  in_2c_data;
  logic [6:0]  in_2d_data;
  logic [6:0]  in_clk;
  logic        out_bitslip;
  logic        out_locked;
  logic        out_vsync;
  logic        out_hsync;
  logic        out_de;
  logic [15:0] out_data_r;
  logic [15:0] out_data_g;
  logic [15:0] out_data_b;

  modport master (
    output in_1a_data, in_1b_data, in_1c_data, in_1d_data,
    output in_2a_data, in_2b_data, in_2c_data, in_2d_data, in_clk,
    input  out_bitslip, out_locked, out_vsync, out_hsync, out_de,
    input  out_data_r, out_data_g, out_data_b
  );

  modport slave (
    input  in_1a_data, in_1b_data, in_1c_data, in_1d_data,
    input  in_2a_data, in_2b_data, in_2c_data, in_2d_data, in_clk,
    output out_bitslip, out_locked, out_vsync, out_hsync, out_de,
    output out_data_r, out_data_g, out_data_b
  );
endinterface

// File: rtl/lvds_video_in.sv
// rtl/lvds_video_in.sv - 7:1 LVDS two-pixel video receiver: bitslip word alignment and lane unpacking
// Optional macro LVDS_IN_LINK_CHECK_EN adds a link-1/link-2 sync agreement check to the lock criteria.
module lvds_video_in #(
  parameter int LOCK_COUNT = 16,
  parameter int ERR_LIMIT  = 4,
  parameter int SLIP_WAIT  = 8
) (
  input  logic            clk,
  input  logic            resetn,
  lvds_video_in_if.slave  bus
);
  localparam logic [6:0] CLK_PATTERN = 7'b1100011;

  typedef enum logic [2:0] {HUNT, SLIP, WAIT, VERIFY, LOCKED} state_t;

  state_t     state;
  logic [7:0] match_cnt;
  logic [7:0] wait_cnt;
  logic [3:0] err_cnt;
  logic       s1_valid;
  logic [6:0] s1_1a, s1_1b, s1_1c, s1_1d;
  logic [6:0] s1_2a, s1_2b, s1_2c, s1_2d;
  logic [6:0] s1_clk;

  logic        clk_ok;
  logic        link_ok;
  logic        word_ok;
  logic        stay_locked;
  logic [23:0] pix1;
  logic [23:0] pix2;

  // Returns {r, g, b}; lane bit 6 is the first serial bit.
  function automatic logic [23:0] decode(input logic [6:0] a, input logic [6:0] b,
                                         input logic [6:0] c, input logic [6:0] d);
    logic [7:0] r, g, bl;
    r  = {d[5], d[6], a[1], a[2], a[3], a[4], a[5], a[6]};
    g  = {d[3], d[4], b[2], b[3], b[4], b[5], b[6], a[0]};
    bl = {d[1], d[2], c[3], c[4], c[5], c[6], b[0], b[1]};
    return {r, g, bl};
  endfunction

  assign clk_ok = (s1_clk == CLK_PATTERN);
`ifdef LVDS_IN_LINK_CHECK_EN
  assign link_ok = (s1_2c[2:0] == s1_1c[2:0]);
`else
  assign link_ok = 1'b1;
`endif
  assign word_ok = clk_ok && link_ok;
  // Still in LOCKED after this edge: drives out_locked and the video gate.
  assign stay_locked = (state == LOCKED) && (word_ok || (err_cnt != 4'(ERR_LIMIT - 1)));
  assign pix1 = decode(s1_1a, s1_1b, s1_1c, s1_1d);
  assign pix2 = decode(s1_2a, s1_2b, s1_2c, s1_2d);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= HUNT;
      match_cnt       <= '0;
      wait_cnt        <= '0;
      err_cnt         <= '0;
      s1_valid        <= 1'b0;
      s1_1a           <= '0;
      s1_1b           <= '0;
      s1_1c           <= '0;
      s1_1d           <= '0;
      s1_2a           <= '0;
      s1_2b           <= '0;
      s1_2c           <= '0;
      s1_2d           <= '0;
      s1_clk          <= '0;
      bus.out_bitslip <= 1'b0;
      bus.out_locked  <= 1'b0;
      bus.out_vsync   <= 1'b0;
      bus.out_hsync   <= 1'b0;
      bus.out_de      <= 1'b0;
      bus.out_data_r  <= '0;
      bus.out_data_g  <= '0;
      bus.out_data_b  <= '0;
    end else begin
      s1_valid <= 1'b1;
      s1_1a    <= bus.in_1a_data;
      s1_1b    <= bus.in_1b_data;
      s1_1c    <= bus.in_1c_data;
      s1_1d    <= bus.in_1d_data;
      s1_2a    <= bus.in_2a_data;
      s1_2b    <= bus.in_2b_data;
      s1_2c    <= bus.in_2c_data;
      s1_2d    <= bus.in_2d_data;
      s1_clk   <= bus.in_clk;

      bus.out_bitslip <= 1'b0;
      bus.out_locked  <= stay_locked;
      bus.out_vsync   <= 1'b0;
      bus.out_hsync   <= 1'b0;
      bus.out_de      <= 1'b0;
      bus.out_data_r  <= '0;
      bus.out_data_g  <= '0;
      bus.out_data_b  <= '0;

      if (stay_locked) begin
        bus.out_hsync <= s1_1c[2];
        bus.out_vsync <= s1_1c[1];
        bus.out_de    <= s1_1c[0];
        if (s1_1c[0]) begin
          bus.out_data_r <= {pix2[23:16], pix1[23:16]};
          bus.out_data_g <= {pix2[15:8],  pix1[15:8]};
          bus.out_data_b <= {pix2[7:0],   pix1[7:0]};
        end
      end

      case (state)
        HUNT: begin
          // Stage 1 holds reset zeros in the first cycle; judging them would cost a needless slip.
          if (s1_valid) begin
            if (clk_ok) begin
              state     <= VERIFY;
              match_cnt <= 8'd1;
            end else begin
              state           <= SLIP;
              bus.out_bitslip <= 1'b1;
            end
          end
        end
        SLIP: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (wait_cnt == 8'(SLIP_WAIT - 1)) begin
            state <= HUNT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        VERIFY: begin
          if (word_ok) begin
            match_cnt <= match_cnt + 8'd1;
            if (match_cnt == 8'(LOCK_COUNT - 1)) begin
              state   <= LOCKED;
              err_cnt <= '0;
            end
          end else begin
            state           <= SLIP;
            bus.out_bitslip <= 1'b1;
          end
        end
        LOCKED: begin
          if (word_ok) begin
            err_cnt <= '0;
          end else if (err_cnt == 4'(ERR_LIMIT - 1)) begin
            state           <= SLIP;
            err_cnt         <= '0;
            bus.out_bitslip <= 1'b1;
          end else begin
            err_cnt <= err_cnt + 4'd1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end
endmodule
